// File: rtl/mem_write_monitor.sv
//------------------------------------------------------------------------------
// mem_write_monitor : checks core data-memory writes against an expected FIFO.
// Optional timeout counter and TOUT state are built when MON_TIMEOUT_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_write_monitor #(
    parameter int          AW       = 32,
    parameter int          DW       = 32,
    parameter int          DEPTH    = 8,
    parameter logic [AW-1:0] IGN_BASE = 80,
    parameter logic [AW-1:0] IGN_MASK = 32'hFFFF_FFFF,
    parameter int          TIMEOUT  = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       exp_push,
    input  logic [AW-1:0]              exp_addr,
    input  logic [DW-1:0]              exp_data,
    output logic                       exp_full,
    input  logic                       start,
    input  logic                       memwrite,
    input  logic [AW-1:0]              dataadr,
    input  logic [DW-1:0]              writedata,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic                       timeout,
    output logic [$clog2(DEPTH+1)-1:0] match_count,
    output logic [AW-1:0]              err_addr,
    output logic [DW-1:0]              err_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_PASS = 3'd2,
        S_FAIL = 3'd3,
        S_TOUT = 3'd4
    } state_t;

    state_t          state_q;
    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, match_count_q;
    logic            exp_full_q, busy_q, done_q, pass_q, fail_q;
    logic [AW-1:0]   err_addr_q;
    logic [DW-1:0]   err_data_q;

    logic push_en, head_hit, ign_hit;

    assign push_en  = (state_q == S_IDLE) && exp_push && !exp_full_q && !reset && !clear;
    assign head_hit = memwrite && (count_q != '0) && (mem_q[rd_ptr_q] == {dataadr, writedata});
    assign ign_hit  = ((dataadr & IGN_MASK) == IGN_BASE);

    // Storage needs no reset: entries are only read while occupancy is non-zero.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= {exp_addr, exp_data};
        end
    end

`ifdef MON_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] tcnt_q;
    logic          timeout_q;
`endif

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            match_count_q <= '0;
            exp_full_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            err_addr_q    <= '0;
            err_data_q    <= '0;
`ifdef MON_TIMEOUT_EN
            tcnt_q        <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (push_en) begin
                        wr_ptr_q   <= wr_ptr_q + 1'b1;
                        count_q    <= count_q + 1'b1;
                        exp_full_q <= (count_q == CW'(DEPTH-1));
                    end
                    if (start) begin
                        if (count_q != '0) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_PASS;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end
`ifdef MON_TIMEOUT_EN
                        tcnt_q <= '0;
`endif
                    end
                end
                S_RUN: begin
                    // Match beats fail, fail beats timeout.
                    if (head_hit) begin
                        rd_ptr_q      <= rd_ptr_q + 1'b1;
                        count_q       <= count_q - 1'b1;
                        match_count_q <= match_count_q + 1'b1;
                        exp_full_q    <= 1'b0;
`ifdef MON_TIMEOUT_EN
                        tcnt_q        <= '0;
`endif
                        if (count_q == CW'(1)) begin
                            state_q <= S_PASS;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end
                    end else if (memwrite && !ign_hit) begin
                        state_q    <= S_FAIL;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        fail_q     <= 1'b1;
                        err_addr_q <= dataadr;
                        err_data_q <= writedata;
                    end
`ifdef MON_TIMEOUT_EN
                    else if (tcnt_q == TW'(TIMEOUT-1)) begin
                        state_q   <= S_TOUT;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
`endif
                end
                S_PASS, S_FAIL, S_TOUT: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign exp_full    = exp_full_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign match_count = match_count_q;
    assign err_addr    = err_addr_q;
    assign err_data    = err_data_q;
`ifdef MON_TIMEOUT_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_write_monitor.sv
//------------------------------------------------------------------------------
// tb_mem_write_monitor : directed and randomized checks against a queue model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_write_monitor;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam logic [31:0] IGN = 32'd80;
`ifdef MON_TIMEOUT_EN
    localparam bit TOEN = 1'b1;
`else
    localparam bit TOEN = 1'b0;
`endif

    localparam int ST_IDLE = 0, ST_RUN = 1, ST_PASS = 2, ST_FAIL = 3, ST_TOUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0, clear = 1'b0, exp_push = 1'b0, start = 1'b0, memwrite = 1'b0;
    logic [31:0] exp_addr = '0, exp_data = '0, dataadr = '0, writedata = '0;
    logic        exp_full, busy, done, pass, fail, timeout;
    logic [2:0]  match_count;
    logic [31:0] err_addr, err_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of expected writes plus spec-level status.
    logic [63:0] m_q[$];
    int          m_state   = ST_IDLE;
    int          m_matches = 0;
    int          m_since   = 0;
    logic [31:0] m_ea = '0, m_ed = '0;

    always #5 clk = ~clk;

    mem_write_monitor #(
        .AW(32), .DW(32), .DEPTH(DEPTH), .IGN_BASE(IGN),
        .IGN_MASK(32'hFFFF_FFFF), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .exp_push(exp_push), .exp_addr(exp_addr), .exp_data(exp_data), .exp_full(exp_full),
        .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .match_count(match_count), .err_addr(err_addr), .err_data(err_data)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rs, input bit cl, input bit ps, input logic [31:0] pa,
                              input logic [31:0] pd, input bit st, input bit mw,
                              input logic [31:0] wa, input logic [31:0] wd);
        int old_size;
        if (rs || cl) begin
            m_q.delete();
            m_state = ST_IDLE; m_matches = 0; m_since = 0; m_ea = '0; m_ed = '0;
        end else if (m_state == ST_IDLE) begin
            old_size = m_q.size();
            if (ps && m_q.size() < DEPTH) m_q.push_back({pa, pd});
            if (st) begin
                m_state = (old_size > 0) ? ST_RUN : ST_PASS;
                m_since = 0;
            end
        end else if (m_state == ST_RUN) begin
            if (mw && m_q.size() > 0 && m_q[0] == {wa, wd}) begin
                void'(m_q.pop_front());
                m_matches++;
                m_since = 0;
                if (m_q.size() == 0) m_state = ST_PASS;
            end else if (mw && wa != IGN) begin
                m_state = ST_FAIL; m_ea = wa; m_ed = wd;
            end else begin
                m_since++;
                if (TOEN && m_since == TIMEOUT) m_state = ST_TOUT;
            end
        end
    endtask

    task automatic compare_all();
        check_val("busy",        64'(busy),        64'(m_state == ST_RUN));
        check_val("done",        64'(done),        64'(m_state >= ST_PASS));
        check_val("pass",        64'(pass),        64'(m_state == ST_PASS));
        check_val("fail",        64'(fail),        64'(m_state == ST_FAIL));
        check_val("timeout",     64'(timeout),     64'(m_state == ST_TOUT));
        check_val("exp_full",    64'(exp_full),    64'(m_q.size() == DEPTH));
        check_val("match_count", 64'(match_count), 64'(m_matches));
        check_val("err_addr",    64'(err_addr),    64'(m_ea));
        check_val("err_data",    64'(err_data),    64'(m_ed));
    endtask

    task automatic step(input bit rs, input bit cl, input bit ps, input logic [31:0] pa,
                        input logic [31:0] pd, input bit st, input bit mw,
                        input logic [31:0] wa, input logic [31:0] wd);
        @(negedge clk);
        reset = rs; clear = cl; exp_push = ps; exp_addr = pa; exp_data = pd;
        start = st; memwrite = mw; dataadr = wa; writedata = wd;
        model_step(rs, cl, ps, pa, pd, st, mw, wa, wd);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();                          step(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_clear();                          step(0, 1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_idle();                           step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_start();                          step(0, 0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic do_push(input logic [31:0] a, input logic [31:0] d);  step(0, 0, 1, a, d, 0, 0, 0, 0); endtask
    task automatic do_write(input logic [31:0] a, input logic [31:0] d); step(0, 0, 0, 0, 0, 0, 1, a, d); endtask

    initial begin
        int r;
        logic [31:0] a, d;

        // Reset state
        do_reset();
        check_val("rst_done", 64'(done), 64'(0));

        // Expected pass with an ignored write first
        do_push(84, 7); do_start(); do_write(80, 5); do_write(84, 7);
        check_val("tp_pass", 64'(pass), 64'(1));
        check_val("tp_pass_mc", 64'(match_count), 64'(1));

        // Wrong address, later correct write stays failed
        do_reset(); do_push(84, 7); do_start(); do_write(88, 7);
        check_val("tp_waddr", 64'(err_addr), 64'(88));
        do_write(84, 7);
        check_val("tp_sticky", 64'(fail), 64'(1));

        // Wrong data
        do_reset(); do_push(84, 7); do_start(); do_write(84, 6);
        check_val("tp_wdata", 64'(err_data), 64'(6));

        // Capacity and order
        do_reset();
        for (int k = 0; k < 5; k++) do_push(32'(k * 4), 32'(k + 1));
        check_val("tp_full", 64'(exp_full), 64'(1));
        do_start();
        for (int k = 0; k < 4; k++) do_write(32'(k * 4), 32'(k + 1));
        check_val("tp_order_mc", 64'(match_count), 64'(4));
        do_reset();
        for (int k = 0; k < 4; k++) do_push(32'(k * 4), 32'(k + 1));
        do_start(); do_write(4, 2);
        check_val("tp_order_fail", 64'(err_addr), 64'(4));

        // Start with empty FIFO goes to PASS
        do_reset(); do_start();
        check_val("tp_empty_start", 64'(pass), 64'(1));

        // Timeout boundary
        do_reset(); do_push(84, 7); do_start();
        for (int k = 0; k < 15; k++) do_idle();
        check_val("tp_tout_pre", 64'(timeout), 64'(0));
        do_idle();
        check_val("tp_tout_edge", 64'(timeout), 64'(TOEN));
        for (int k = 0; k < 100; k++) do_idle();

        // Match on the 15th run cycle restarts the count
        do_reset(); do_push(84, 7); do_push(88, 9); do_start();
        for (int k = 0; k < 14; k++) do_idle();
        do_write(84, 7);
        for (int k = 0; k < 20; k++) do_idle();

        // Reset and clear mid-run, then a fresh passing sequence
        do_reset(); do_push(84, 7); do_push(88, 9); do_start(); do_write(84, 7);
        do_reset();
        do_push(84, 7); do_push(88, 9); do_start(); do_write(84, 7);
        do_clear();
        check_val("tp_clear_mc", 64'(match_count), 64'(0));
        do_push(84, 7); do_start(); do_write(84, 7);
        check_val("tp_after_clear", 64'(pass), 64'(1));

        // Randomized sequences
        for (int it = 0; it < 40; it++) begin
            do_reset();
            r = $urandom_range(0, 5);
            for (int k = 0; k < r; k++) begin
                a = ($urandom_range(0, 7) == 0) ? IGN : 32'($urandom_range(0, 31) * 4);
                d = 32'($urandom_range(0, 3));
                do_push(a, d);
            end
            do_start();
            for (int c = 0; c < 30; c++) begin
                r = $urandom_range(0, 9);
                if (r <= 4 && m_q.size() > 0) do_write(m_q[0][63:32], m_q[0][31:0]);
                else if (r <= 6) do_write(IGN, 32'($urandom_range(0, 3)));
                else if (r == 7) do_write(32'($urandom_range(0, 31) * 4), 32'($urandom_range(0, 3)));
                else if (r == 9 && $urandom_range(0, 3) == 0) do_clear();
                else do_idle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_write_monitor.md
# mem_write_monitor

Synthesizable, parametrised checker for the data-memory write port of the pipelined MIPS core. It sits beside `top` in the bench, or on-chip for FPGA self-test. It compares every `memwrite` transaction against an ordered list of expected (address, data) pairs held in an internal FIFO, and skips writes to a configurable scratch region. It reports pass, fail (with the offending write captured), or timeout as registered status flags.

## Interface
Parameters:
- `AW`, 32: data-address width.
- `DW`, 32: write-data width.
- `DEPTH`, 8: expected-write FIFO depth (power of two, ≥2).
- `IGN_BASE`, 80: base of the ignored address region.
- `IGN_MASK`, 32'hFFFF_FFFF: an address is ignored when `(dataadr & IGN_MASK) == IGN_BASE`.
- `TIMEOUT`, 1000: cycles allowed without a match before timeout (≥2).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `clear`, in, 1: synchronous soft reset; same effect as `reset`.
- `exp_push`, in, 1: push one expected write.
- `exp_addr`, in, AW: expected address.
- `exp_data`, in, DW: expected data.
- `exp_full`, out, 1: FIFO full.
- `start`, in, 1: begin checking.
- `memwrite`, in, 1: core write strobe.
- `dataadr`, in, AW: core write address.
- `writedata`, in, DW: core write data.
- `busy`, out, 1: state is RUN.
- `done`, out, 1: state is PASS, FAIL or TOUT.
- `pass`, out, 1: all expected writes matched in order.
- `fail`, out, 1: mismatching or unexpected write.
- `timeout`, out, 1: timeout expired.
- `match_count`, out, $clog2(DEPTH+1): number of writes matched so far.
- `err_addr`, out, AW: address of the first offending write.
- `err_data`, out, DW: data of the first offending write.

## Operation
- States: IDLE, RUN, PASS, FAIL, TOUT. `reset` or `clear` forces IDLE from any state, empties the FIFO, and zeroes every output, counter and capture register.
- IDLE:
  - `exp_push` with `!exp_full` writes the entry at the tail.
  - Pushes when full, or in any other state, are dropped.
  - `start` moves to RUN if the FIFO is non-empty. If the FIFO is empty, `start` moves straight to PASS.
- RUN: on each cycle with `memwrite=1`:
  - If `dataadr`/`writedata` equal the head entry: pop the head, increment `match_count`, reload the timeout counter. If this was the last entry, go to PASS.
  - Else if the address is in the ignore region: no action.
  - Else: go to FAIL and capture `err_addr`/`err_data`.
- Head matching takes priority over the ignore check. A write to an ignored address that equals the head entry counts as a match.
- PASS, FAIL and TOUT are sticky until `reset`/`clear`. `memwrite` is not evaluated in them, and `start` is ignored.
- `memwrite` is not evaluated in IDLE. If `start` and `memwrite` arrive in the same cycle, that write is not checked.
- Comparison is exact over the full `AW`/`DW` width. `x`/`z` on inputs is not handled specially.

## Timing
- All outputs are registered. A write sampled at edge k is reflected in status and `match_count` after edge k, so they are visible in cycle k+1.
- `start` at edge k gives `busy=1` from cycle k+1.
- `exp_full` updates the cycle after the push that fills the FIFO.
- Timeout counter:
  - Cleared on entry to RUN and on every match.
  - Increments on every other RUN cycle.
  - Going to TOUT: when the counter equals `TIMEOUT-1` and the cycle has no match, the block enters TOUT. TOUT is therefore reached exactly `TIMEOUT` cycles after the last progress.
- Precedence when events coincide: match, then fail, then timeout. A match in the expiry cycle wins, and a mismatch in the expiry cycle reports FAIL.
- FIFO pointers wrap modulo DEPTH. A separate occupancy count of $clog2(DEPTH+1) bits distinguishes full from empty.

## Configuration
- Macro `MON_TIMEOUT_EN`.
- Defined: the timeout counter and the TOUT state are built, as described above.
- Undefined: no counter is built, `timeout` is tied to 0, and RUN waits indefinitely. `TIMEOUT` is unused.

## Test plan
- Expected pass: push (84,7), `start`, then writes (80,5) and (84,7) → after the second write `pass=1`, `done=1`, `match_count=1`, `fail=0`.
- Wrong address: push (84,7), `start`, write (88,7) → `fail=1`, `err_addr=88`, `err_data=7`, `match_count=0`. A later write of (84,7) leaves `fail=1`.
- Wrong data: push (84,7), `start`, write (84,6) → `fail=1`, `err_data=6`.
- FIFO capacity and order (DEPTH=4):
  - Push (0,1), (4,2), (8,3), (12,4), (16,5): `exp_full=1` after the 4th push, and the 5th push is dropped.
  - Writes in order → `pass` with `match_count=4`.
  - Rerun with (4,2) written first → `fail`, `err_addr=4`.
- Timeout (TIMEOUT=16, macro defined):
  - Push one entry, `start`, no writes → `timeout=1` exactly 16 cycles after `busy` rises.
  - A match at cycle 15 resets the count.
  - With the macro undefined, `busy` stays 1 and `timeout=0` after 100 cycles.
- Reset/clear mid-RUN: after one match, assert `reset` (and separately `clear`) for one cycle → all outputs 0, FIFO empty, IDLE. A new push/start sequence then passes.
